// File: rtl/fft_pingpong_ram.sv
// rtl/fft_pingpong_ram.sv - double-buffered frame RAM between the sample source and the FFT core
`timescale 1ns/1ps

module fft_pingpong_ram #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int BIT_REVERSE = 0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  WR_VALID,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  output logic                  WR_READY,
  output logic                  WR_BANK,
  output logic                  FRAME_READY,
  output logic                  RD_BANK,
  input  logic                  RD_EN,
  input  logic [ADDR_WIDTH-1:0] RD_ADDR,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  RD_VALID,
  input  logic                  RD_DONE,
  output logic                  OVERFLOW
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [2*DEPTH];

  logic [1:0]            bank_full;
  logic                  wr_bank;
  logic                  rd_bank;
  logic [ADDR_WIDTH-1:0] wr_cnt;
  logic [ADDR_WIDTH-1:0] wr_cnt_rev;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [1:0]            bank_full_nxt;

  logic wr_fire;
  logic wr_block;
  logic wr_last;
  logic rd_fire;
  logic rel_fire;

  assign WR_READY    = !bank_full[wr_bank];
  assign FRAME_READY = bank_full[rd_bank];
  assign WR_BANK     = wr_bank;
  assign RD_BANK     = rd_bank;

  assign wr_fire  = WR_VALID && WR_READY;
  assign wr_block = WR_VALID && !WR_READY;
  assign wr_last  = &wr_cnt;
  assign rd_fire  = RD_EN && FRAME_READY;
  assign rel_fire = RD_DONE && FRAME_READY;

  always_comb begin
    wr_cnt_rev = '0;
    for (int i = 0; i < ADDR_WIDTH; i++) begin
      wr_cnt_rev[i] = wr_cnt[ADDR_WIDTH-1-i];
    end
  end

  assign waddr = (BIT_REVERSE != 0) ? wr_cnt_rev : wr_cnt;

  // Release and frame completion never target the same bank: a full bank is not writable.
  always_comb begin
    bank_full_nxt = bank_full;
    if (rel_fire) begin
      bank_full_nxt[rd_bank] = 1'b0;
    end
    if (wr_fire && wr_last) begin
      bank_full_nxt[wr_bank] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      bank_full <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_cnt    <= '0;
      OVERFLOW  <= 1'b0;
    end else begin
      bank_full <= bank_full_nxt;
      if (wr_fire) begin
        wr_cnt <= wr_cnt + ADDR_WIDTH'(1);
        if (wr_last) begin
          wr_bank <= !wr_bank;
        end
      end
      if (rel_fire) begin
        rd_bank <= !rd_bank;
      end
      if (wr_block) begin
        OVERFLOW <= 1'b1;
      end
    end
  end

  // Storage has no reset so it maps onto block RAM.
  always_ff @(posedge CLK) begin
    if (wr_fire) begin
      mem[{wr_bank, waddr}] <= WR_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      RD_DATA  <= '0;
      RD_VALID <= 1'b0;
    end else begin
      RD_VALID <= rd_fire;
      if (rd_fire) begin
        RD_DATA <= mem[{rd_bank, RD_ADDR}];
      end
    end
  end

endmodule

// File: tb/tb_fft_pingpong_ram.sv
// tb/tb_fft_pingpong_ram.sv - self-checking bench for fft_pingpong_ram
`timescale 1ns/1ps

module tb_fft_pingpong_ram;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        WR_VALID, RD_EN, RD_DONE;
  logic [15:0] WR_DATA;
  logic [2:0]  RD_ADDR;
  logic        WR_READY, WR_BANK, FRAME_READY, RD_BANK, RD_VALID, OVERFLOW;
  logic [15:0] RD_DATA;

  logic        r_wr_valid, r_rd_en, r_rd_done;
  logic [15:0] r_wr_data;
  logic [2:0]  r_rd_addr;
  logic        r_wr_ready, r_wr_bank, r_frame_ready, r_rd_bank, r_rd_valid, r_overflow;
  logic [15:0] r_rd_data;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  always #5 CLK = !CLK;

  fft_pingpong_ram #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .BIT_REVERSE(0)) u_dut (
    .CLK(CLK), .RST_N(RST_N),
    .WR_VALID(WR_VALID), .WR_DATA(WR_DATA), .WR_READY(WR_READY), .WR_BANK(WR_BANK),
    .FRAME_READY(FRAME_READY), .RD_BANK(RD_BANK),
    .RD_EN(RD_EN), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID),
    .RD_DONE(RD_DONE), .OVERFLOW(OVERFLOW)
  );

  fft_pingpong_ram #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .BIT_REVERSE(1)) u_rev (
    .CLK(CLK), .RST_N(RST_N),
    .WR_VALID(r_wr_valid), .WR_DATA(r_wr_data), .WR_READY(r_wr_ready), .WR_BANK(r_wr_bank),
    .FRAME_READY(r_frame_ready), .RD_BANK(r_rd_bank),
    .RD_EN(r_rd_en), .RD_ADDR(r_rd_addr), .RD_DATA(r_rd_data), .RD_VALID(r_rd_valid),
    .RD_DONE(r_rd_done), .OVERFLOW(r_overflow)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: completed frames queue up in write order, the reader sees the oldest.
  logic [127:0] fq[$];
  logic [127:0] part;
  logic [127:0] head;
  int           pcnt, wcount, rcount;
  bit           m_ovf, m_rv;
  logic [15:0]  m_rd;
  bit           have, room;

  always @(posedge CLK) begin
    if (!RST_N) begin
      fq.delete();
      part = '0; pcnt = 0; wcount = 0; rcount = 0;
      m_ovf = 0; m_rv = 0; m_rd = '0;
    end else begin
      have = fq.size() > 0;
      room = fq.size() < 2;
      if (RD_EN && have) begin
        head = fq[0];
        m_rd = head[int'(RD_ADDR)*16 +: 16];
        m_rv = 1;
      end else begin
        m_rv = 0;
      end
      if (RD_DONE && have) begin
        void'(fq.pop_front());
        rcount++;
      end
      if (WR_VALID && !room) begin
        m_ovf = 1;
      end else if (WR_VALID) begin
        part[pcnt*16 +: 16] = WR_DATA;
        pcnt++;
        if (pcnt == 8) begin
          fq.push_back(part);
          pcnt = 0;
          wcount++;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (mon_en) begin
      check("mdl_wr_ready",    int'(WR_READY),    int'(fq.size() < 2));
      check("mdl_frame_ready", int'(FRAME_READY), int'(fq.size() > 0));
      check("mdl_wr_bank",     int'(WR_BANK),     wcount % 2);
      check("mdl_rd_bank",     int'(RD_BANK),     rcount % 2);
      check("mdl_overflow",    int'(OVERFLOW),    int'(m_ovf));
      check("mdl_rd_valid",    int'(RD_VALID),    int'(m_rv));
      check("mdl_rd_data",     int'(RD_DATA),     int'(m_rd));
    end
  end

  task automatic wr(input logic [15:0] d);
    WR_VALID = 1'b1; WR_DATA = d;
    @(negedge CLK);
    WR_VALID = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a);
    RD_EN = 1'b1; RD_ADDR = a;
    @(negedge CLK);
    RD_EN = 1'b0;
  endtask

  task automatic done();
    RD_DONE = 1'b1;
    @(negedge CLK);
    RD_DONE = 1'b0;
  endtask

  task automatic reset_pulse(input int n);
    RST_N = 1'b0;
    repeat (n) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    RST_N = 1'b0;
    WR_VALID = 0; WR_DATA = '0; RD_EN = 0; RD_ADDR = '0; RD_DONE = 0;
    r_wr_valid = 0; r_wr_data = '0; r_rd_en = 0; r_rd_addr = '0; r_rd_done = 0;
    repeat (2) @(negedge CLK);
    mon_en = 1'b1;
    check("rst_wr_ready", int'(WR_READY), 1);
    check("rst_frame_ready", int'(FRAME_READY), 0);
    check("rst_rd_valid", int'(RD_VALID), 0);
    check("rst_rd_data", int'(RD_DATA), 0);
    check("rst_overflow", int'(OVERFLOW), 0);
    RST_N = 1'b1;

    // linear frame, one-cycle read latency, then ignored read/release on an empty bank
    for (int i = 1; i <= 7; i++) wr(16'(i));
    check("t1_not_ready_7", int'(FRAME_READY), 0);
    wr(16'd8);
    check("t1_frame_ready", int'(FRAME_READY), 1);
    check("t1_wr_bank", int'(WR_BANK), 1);
    for (int a = 0; a < 8; a++) begin
      rd(3'(a));
      check("t1_rd_valid", int'(RD_VALID), 1);
      check("t1_rd_data", int'(RD_DATA), a + 1);
    end
    @(negedge CLK);
    check("t1_valid_drop", int'(RD_VALID), 0);
    done();
    check("t4_rd_bank_before", int'(RD_BANK), 1);
    RD_EN = 1'b1; RD_ADDR = 3'd2; RD_DONE = 1'b1;
    @(negedge CLK);
    RD_EN = 1'b0; RD_DONE = 1'b0;
    check("t4_rd_valid", int'(RD_VALID), 0);
    check("t4_rd_data_hold", int'(RD_DATA), 8);
    check("t4_rd_bank", int'(RD_BANK), 1);

    // both banks full, overflow drop, release
    reset_pulse(1);
    for (int i = 1; i <= 16; i++) wr(16'(i));
    check("t3_wr_ready", int'(WR_READY), 0);
    wr(16'd99);
    check("t3_overflow", int'(OVERFLOW), 1);
    rd(3'd7);
    check("t3_bank0_last", int'(RD_DATA), 8);
    done();
    check("t3_rd_bank", int'(RD_BANK), 1);
    check("t3_frame_ready", int'(FRAME_READY), 1);
    check("t3_wr_ready_after", int'(WR_READY), 1);
    check("t3_overflow_sticky", int'(OVERFLOW), 1);
    rd(3'd0);
    check("t3_bank1_first", int'(RD_DATA), 9);

    // reset mid-frame discards the partial frame
    for (int i = 0; i < 5; i++) wr(16'(100 + i));
    reset_pulse(1);
    check("t5_wr_bank", int'(WR_BANK), 0);
    check("t5_frame_ready", int'(FRAME_READY), 0);
    check("t5_overflow", int'(OVERFLOW), 0);
    for (int i = 0; i < 7; i++) wr(16'(200 + i));
    check("t5_not_ready_7", int'(FRAME_READY), 0);
    wr(16'd207);
    check("t5_ready_8", int'(FRAME_READY), 1);
    rd(3'd0);
    check("t5_first", int'(RD_DATA), 200);

    // last write of bank 1 coincides with read + release of bank 0
    reset_pulse(1);
    for (int i = 1; i <= 8; i++) wr(16'(i));
    for (int i = 11; i <= 17; i++) wr(16'(i));
    rd(3'd2);
    check("t6_pre_read", int'(RD_DATA), 3);
    WR_VALID = 1'b1; WR_DATA = 16'd18; RD_EN = 1'b1; RD_ADDR = 3'd5; RD_DONE = 1'b1;
    @(negedge CLK);
    WR_VALID = 1'b0; RD_EN = 1'b0; RD_DONE = 1'b0;
    check("t6_rd_data_old", int'(RD_DATA), 6);
    check("t6_rd_valid", int'(RD_VALID), 1);
    check("t6_rd_bank", int'(RD_BANK), 1);
    check("t6_frame_ready", int'(FRAME_READY), 1);
    check("t6_wr_bank", int'(WR_BANK), 0);
    check("t6_wr_ready", int'(WR_READY), 1);
    for (int a = 0; a < 8; a++) begin
      rd(3'(a));
      check("t6_bank1_data", int'(RD_DATA), 11 + a);
    end

    // bit-reversed instance
    for (int i = 0; i < 8; i++) begin
      r_wr_valid = 1'b1; r_wr_data = 16'(i);
      @(negedge CLK);
    end
    r_wr_valid = 1'b0;
    check("t2_frame_ready", int'(r_frame_ready), 1);
    for (int k = 0; k < 4; k++) begin
      logic [2:0] addrs [4];
      int         exps  [4];
      addrs = '{3'd1, 3'd3, 3'd6, 3'd7};
      exps  = '{4, 6, 3, 7};
      r_rd_en = 1'b1; r_rd_addr = addrs[k];
      @(negedge CLK);
      r_rd_en = 1'b0;
      check("t2_rev_valid", int'(r_rd_valid), 1);
      check("t2_rev_data", int'(r_rd_data), exps[k]);
    end

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
